// File: rtl/counter_event_pkg.sv
// Shared definitions for the counter event logger: flag bit positions,
// the sampling FSM states and the flag vector type.
package counter_event_pkg;

    localparam int FLAG_WRAP  = 0;
    localparam int FLAG_JUMP  = 1;
    localparam int FLAG_MATCH = 2;
    localparam int FLAG_COUNT = 3;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef logic [FLAG_COUNT-1:0] flags_t;

    // Total packed width of one queued event {flags, epoch, count}.
    function automatic int entry_width(input int size, input int epoch_width);
        return FLAG_COUNT + epoch_width + size;
    endfunction

endpackage

// File: rtl/counter_event_fifo.sv
// Small synchronous FIFO for event entries. A push while full is only
// accepted when a pop happens on the same edge; otherwise it is ignored and
// the caller is expected to flag the drop. Head data is read combinationally
// from the storage array, so there is no fall-through from push to head.
module counter_event_fifo #(
    parameter int Depth = 4,
    parameter int Width = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    output logic [Width-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);

    localparam int AddrWidth = $clog2(Depth);
    localparam logic [AddrWidth:0] FullCount = (AddrWidth+1)'(Depth);

    logic [Width-1:0]     mem [Depth];
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic                 push_en;
    logic                 pop_en;

    assign full     = (count == FullCount);
    assign empty    = (count == '0);
    assign pop_en   = pop && !empty;
    assign push_en  = push && (!full || pop_en);
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates validity.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; Depth is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/counter_event_logger.sv
// Watches a free-running counter and queues wrap, jump and match events,
// each tagged with the wrap epoch, for draining over a valid/ready stream.
//
// state | meaning
// PRIME | first sample after reset: capture prev_count, no detection
// RUN   | compare each sample against prev_count and push events
module counter_event_logger
    import counter_event_pkg::*;
#(
    parameter int Size       = 5,
    parameter int Depth      = 4,
    parameter int EpochWidth = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [Size-1:0]            count,
    input  logic                       match_enable,
    input  logic [Size-1:0]            match_value,
    output logic                       event_valid,
    input  logic                       event_ready,
    output logic [2:0]                 event_flags,
    output logic [EpochWidth-1:0]      event_epoch,
    output logic [Size-1:0]            event_count,
    output logic [$clog2(Depth):0]     occupancy,
    output logic                       overflow
);

    localparam int EntryWidth = entry_width(Size, EpochWidth);

    // Event entry layout; widths follow this instance's parameters.
    typedef struct packed {
        flags_t                flags;
        logic [EpochWidth-1:0] epoch;
        logic [Size-1:0]       count;
    } entry_t;

    state_t                state;
    logic [Size-1:0]       prev_count;
    logic [EpochWidth-1:0] epoch;
    logic [EpochWidth-1:0] epoch_inc;
    logic [Size-1:0]       count_inc;

    logic   wrap;
    logic   jump;
    logic   match;
    logic   push;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t push_entry;
    entry_t head_entry;
    entry_t head_shown;

    assign count_inc = prev_count + 1'b1;
    assign epoch_inc = epoch + 1'b1;

    // Event detection on the current sample; all compares are modulo 2^Size.
    always_comb begin
        wrap  = 1'b0;
        jump  = 1'b0;
        match = 1'b0;
        if (state == RUN) begin
            wrap  = (prev_count == {Size{1'b1}}) && (count == '0);
            jump  = (count != prev_count) && (count != count_inc);
            match = match_enable && (count == match_value) && (count != prev_count);
        end
    end

    // Build the merged entry; a wrap is stamped with the epoch it opens.
    always_comb begin
        push_entry                   = '0;
        push_entry.flags[FLAG_WRAP]  = wrap;
        push_entry.flags[FLAG_JUMP]  = jump;
        push_entry.flags[FLAG_MATCH] = match;
        push_entry.epoch             = wrap ? epoch_inc : epoch;
        push_entry.count             = count;
    end

    assign push = |push_entry.flags;
    assign pop  = !fifo_empty && event_ready;

    // Sampling FSM: prev_count tracking, epoch advance and sticky drop flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= PRIME;
            prev_count <= '0;
            epoch      <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    prev_count <= count;
                    state      <= RUN;
                end
                RUN: begin
                    prev_count <= count;
                    if (wrap) begin
                        epoch <= epoch_inc;
                    end
                    if (push && fifo_full && !pop) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

    counter_event_fifo #(
        .Depth (Depth),
        .Width (EntryWidth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // Stale storage is never exposed: outputs read zero whenever empty.
    assign head_shown  = fifo_empty ? '0 : head_entry;
    assign event_valid = !fifo_empty;
    assign event_flags = head_shown.flags;
    assign event_epoch = head_shown.epoch;
    assign event_count = head_shown.count;

endmodule

// File: tb/tb_counter_event_logger.sv
// Randomised and directed bench for counter_event_logger with a behavioural
// reference model and a queue-based scoreboard drained by a monitor.
module tb_counter_event_logger;

    localparam int SIZE  = 5;
    localparam int DEPTH = 4;
    localparam int EW    = 8;
    localparam int MOD   = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] count = '0;
    logic       match_enable = 1'b0;
    logic [4:0] match_value = '0;
    logic       event_ready = 1'b0;
    logic       event_valid;
    logic [2:0] event_flags;
    logic [7:0] event_epoch;
    logic [4:0] event_count;
    logic [2:0] occupancy;
    logic       overflow;

    counter_event_logger #(.Size(SIZE), .Depth(DEPTH), .EpochWidth(EW)) dut (
        .clock        (clock),
        .reset        (reset),
        .count        (count),
        .match_enable (match_enable),
        .match_value  (match_value),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_flags  (event_flags),
        .event_epoch  (event_epoch),
        .event_count  (event_count),
        .occupancy    (occupancy),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int flags;
        int epoch;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    // reference model state
    int  model_occ = 0;
    int  model_ovf = 0;
    int  model_epoch = 0;
    int  prev = 0;
    bit  primed = 1'b0;
    int  cur = 0;
    bit  tb_me = 1'b0;
    int  tb_mv = 0;

    // monitor observations
    int  pops = 0;
    int  last_flags = -1;
    int  last_epoch = -1;
    int  last_count = -1;
    bit  stalled = 1'b0;
    int  s_flags, s_epoch, s_count;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: check state after the last edge, drive new
    // inputs, and advance the model to what the next edge should produce.
    task automatic step(input int c, input bit rdy, input bit rst_n);
        int  fl;
        int  ep;
        bit  pop;
        @(posedge clock);
        #1;
        chk("occupancy", int'(occupancy), model_occ);
        chk("overflow", int'(overflow), model_ovf);
        count        = 5'(c);
        event_ready  = rdy;
        reset        = rst_n;
        match_enable = tb_me;
        match_value  = 5'(tb_mv);
        cur          = c;
        if (!rst_n) begin
            exp_q.delete();
            model_occ   = 0;
            model_ovf   = 0;
            model_epoch = 0;
            primed      = 1'b0;
        end else if (!primed) begin
            primed = 1'b1;
            prev   = c;
        end else begin
            fl = 0;
            ep = model_epoch;
            if (prev == MOD - 1 && c == 0) begin
                fl          = fl | 1;
                model_epoch = (model_epoch + 1) % 256;
                ep          = model_epoch;
            end
            if (c != prev && c != (prev + 1) % MOD) fl = fl | 2;
            if (tb_me && c == tb_mv && c != prev) fl = fl | 4;
            pop = (model_occ > 0) && rdy;
            if (pop) model_occ--;
            if (fl != 0) begin
                if (model_occ < DEPTH) begin
                    model_occ++;
                    exp_q.push_back('{fl, ep, c});
                end else begin
                    model_ovf = 1;
                end
            end
            prev = c;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (model_occ == 0) break;
            step(cur, 1'b1, 1'b1);
        end
        step(cur, 1'b1, 1'b1);
        step(cur, 1'b1, 1'b1);
    endtask

    // Monitor: compare every accepted head against the scoreboard and check
    // that a stalled head holds still.
    always @(negedge clock) begin
        ev_t e;
        if (reset !== 1'b1) begin
            stalled = 1'b0;
        end else if (event_valid) begin
            if (stalled) begin
                chk("stall_flags", int'(event_flags), s_flags);
                chk("stall_epoch", int'(event_epoch), s_epoch);
                chk("stall_count", int'(event_count), s_count);
            end
            if (event_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(event_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_flags", int'(event_flags), e.flags);
                    chk("ev_epoch", int'(event_epoch), e.epoch);
                    chk("ev_count", int'(event_count), e.cnt);
                    pops++;
                    last_flags = int'(event_flags);
                    last_epoch = int'(event_epoch);
                    last_count = int'(event_count);
                end
            end else begin
                stalled = 1'b1;
                s_flags = int'(event_flags);
                s_epoch = int'(event_epoch);
                s_count = int'(event_count);
            end
        end else begin
            stalled = 1'b0;
            chk("idle_outputs", int'({event_flags, event_epoch, event_count}), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r;
        int c;
        bit rdy;
        bit rst_n;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", int'(event_valid), 0);
        chk("rst_flags", int'(event_flags), 0);
        chk("rst_epoch", int'(event_epoch), 0);
        chk("rst_count", int'(event_count), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_overflow", int'(overflow), 0);

        // 1: full lap and wrap
        tb_me = 1'b0;
        p0 = pops;
        for (int i = 0; i < 32; i++) step(i, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        chk("t1_valid_before", int'(event_valid), 0);
        step(1, 1'b1, 1'b1);
        chk("t1_valid_latency", int'(event_valid), 1);
        drain();
        chk("t1_events", pops - p0, 1);
        chk("t1_flags", last_flags, 1);
        chk("t1_epoch", last_epoch, 1);
        chk("t1_count", last_count, 0);

        // 2: edge-style match with held value
        step(0, 1'b1, 1'b0);
        tb_me = 1'b1;
        tb_mv = 7;
        p0 = pops;
        for (int i = 0; i < 8; i++) step(i, 1'b1, 1'b1);
        step(7, 1'b1, 1'b1);
        step(7, 1'b1, 1'b1);
        step(8, 1'b1, 1'b1);
        step(9, 1'b1, 1'b1);
        drain();
        chk("t2_events", pops - p0, 1);
        chk("t2_flags", last_flags, 4);
        chk("t2_epoch", last_epoch, 0);
        chk("t2_count", last_count, 7);

        // 3: wrap and match merge into one entry
        step(0, 1'b1, 1'b0);
        tb_mv = 0;
        p0 = pops;
        step(30, 1'b1, 1'b1);
        step(31, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        drain();
        chk("t3_events", pops - p0, 1);
        chk("t3_flags", last_flags, 5);
        chk("t3_epoch", last_epoch, 1);
        chk("t3_count", last_count, 0);

        // 4: jump, then a hold raises nothing
        step(0, 1'b1, 1'b0);
        tb_me = 1'b0;
        p0 = pops;
        step(3, 1'b1, 1'b1);
        step(4, 1'b1, 1'b1);
        step(10, 1'b1, 1'b1);
        step(10, 1'b1, 1'b1);
        step(11, 1'b1, 1'b1);
        drain();
        chk("t4_events", pops - p0, 1);
        chk("t4_flags", last_flags, 2);
        chk("t4_count", last_count, 10);

        // 5: overflow with consumer stalled
        step(0, 1'b1, 1'b0);
        p0 = pops;
        step(0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(5 * i, 1'b0, 1'b1);
        step(25, 1'b0, 1'b1);
        chk("t5_occupancy", int'(occupancy), 4);
        chk("t5_overflow", int'(overflow), 1);
        drain();
        chk("t5_events", pops - p0, 4);
        chk("t5_last_count", last_count, 20);
        chk("t5_overflow_sticky", int'(overflow), 1);

        // 6: reset discards queue; first sample never matches
        step(0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1);
        step(5, 1'b0, 1'b1);
        step(10, 1'b0, 1'b1);
        step(10, 1'b0, 1'b1);
        chk("t6_queued", int'(occupancy), 2);
        step(10, 1'b0, 1'b0);
        tb_me = 1'b1;
        tb_mv = 3;
        p0 = pops;
        step(3, 1'b1, 1'b1);
        chk("t6_valid", int'(event_valid), 0);
        chk("t6_occupancy", int'(occupancy), 0);
        chk("t6_overflow", int'(overflow), 0);
        chk("t6_epoch", int'(event_epoch), 0);
        step(3, 1'b1, 1'b1);
        step(3, 1'b1, 1'b1);
        chk("t6_no_prime_event", int'(occupancy), 0);
        drain();
        chk("t6_events", pops - p0, 0);
        step(31, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        drain();
        chk("t6_post_events", pops - p0, 2);
        chk("t6_wrap_epoch", last_epoch, 1);

        // random phase
        step(0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                tb_me = 1'($urandom_range(0, 1));
                tb_mv = int'($urandom_range(0, 31));
            end
            r = int'($urandom_range(0, 99));
            if (r < 70)      c = (cur + 1) % MOD;
            else if (r < 82) c = cur;
            else             c = int'($urandom_range(0, 31));
            rdy   = int'($urandom_range(0, 99)) < (((i / 200) % 2 == 1) ? 80 : 30);
            rst_n = ($urandom_range(0, 299) != 0);
            step(c, rdy, rst_n);
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_occupancy", int'(occupancy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_event_logger.md
Name: counter_event_logger

Overview:
Downstream consumer of the free-running `counter` stage. It samples `count` every clock and detects three kinds of event: wrap-around, discontinuous jumps, and arrival at a programmable match value. Each event is tagged with a wrap epoch and queued in a small FIFO. Events drain through a valid/ready stream, so the bench or a later stage can read counter history without polling every cycle.

Parameters:
- Size, 5, width of `count`; must equal the upstream counter's Size.
- Depth, 4, event FIFO entries; power of 2, ≥2.
- EpochWidth, 8, width of the wrap epoch counter.

Ports:
- clock  in  1  rising-edge clock, shared with the counter.
- reset  in  1  synchronous, active-low reset (0 = reset).
- count  in  Size  counter value, sampled each posedge.
- match_enable  in  1  enables match detection.
- match_value  in  Size  value that triggers a match event.
- event_valid  out  1  FIFO head is valid.
- event_ready  in  1  consumer accepts the head this cycle.
- event_flags  out  3  [0] wrap, [1] jump, [2] match.
- event_epoch  out  EpochWidth  epoch recorded with the event.
- event_count  out  Size  sampled count that triggered the event.
- occupancy  out  $clog2(Depth)+1  number of queued events.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO empties.
  - State goes to PRIME.
  - epoch, prev_count and overflow are cleared.
  - Outputs: event_valid=0, event_flags=0, event_epoch=0, event_count=0, occupancy=0, overflow=0.
  - Reset asserted mid-operation discards all queued events on that edge.
- FSM states PRIME and RUN:
  - PRIME: first posedge with reset==1 captures prev_count<=count, raises no event, goes to RUN.
  - RUN: on every posedge, evaluates the rules below, then sets prev_count<=count.
- Detection in RUN, all evaluated on the same sample:
  - wrap = (prev_count == 2^Size-1) && (count == 0).
  - jump = (count != prev_count) && (count != prev_count+1 mod 2^Size).
  - wrap and jump are mutually exclusive by construction.
  - A held value (count == prev_count) raises no wrap or jump.
  - match = match_enable && (count == match_value) && (count != prev_count).
  - Match is edge-style: a held value matches once. The first RUN sample never matches because PRIME already captured it.
- Epoch:
  - Increments (mod 2^EpochWidth, silent wrap) on every wrap.
  - A wrap event records the post-increment epoch; other events record the current epoch.
- Push:
  - Pushes exactly one entry {flags, epoch, count} when any flag is set.
  - Simultaneous conditions merge into one entry (e.g. flags=101 for wrap+match).
- FIFO:
  - Pop when event_valid && event_ready.
  - Full with push and pop in the same cycle: both occur, no drop.
  - Full with push and no pop: the new event is dropped, overflow<=1, and overflow holds until reset.
  - Empty with push: no fall-through; event_valid rises on the next cycle.
  - Latency: an event appears on the outputs 1 cycle after the posedge that sampled the triggering count (when the FIFO was empty).
  - event_* outputs are stable while event_valid && !event_ready.
  - Entries drain in FIFO order.
  - occupancy is updated each cycle as +push −pop.
- Arithmetic: all count comparisons use Size-bit modular arithmetic.

Decomposition:
- Package counter_event_pkg holds:
  - flag bit-index constants FLAG_WRAP=0, FLAG_JUMP=1, FLAG_MATCH=2;
  - the PRIME/RUN state enum;
  - a packed event-entry typedef, parameterised via localparam widths in the top.
- Sub-module counter_event_fifo: synchronous FIFO with Depth and width parameters, push/pop/full/empty/count ports, and the same clock/reset convention.

Test Plan:
1. Reset, Size=5, count runs 0..31,0,1 with ready=1 and match off → exactly one event: flags=001, epoch=1, count=0, valid one cycle after sampling 0.
2. match_enable=1, match_value=7, count runs 0..9 with 7 held for 3 cycles → one event: flags=100, count=7, epoch=0; no repeat while 7 is held.
3. match_value=0, count 30,31,0 → single entry flags=101, epoch=1, count=0; occupancy never exceeds 1.
4. count 3,4,10,11 → one entry flags=010, count=10; count 10,10 (hold) → no entry.
5. ready=0, five jump events, Depth=4 → occupancy=4 and overflow=1; then ready=1 drains the first four events in order, the fifth is absent, and overflow stays 1.
6. Two events queued, reset=0 for one cycle → next cycle event_valid=0, occupancy=0, overflow=0, epoch=0; first sample after release raises no event, even if count==match_value.
